// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Register map, ACTIVE field layout and bus FSM encoding for
//                the irq_ctrl interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PEND   = 3'd0;
    localparam logic [2:0] IRQ_MASK   = 3'd1;
    localparam logic [2:0] IRQ_EDGE   = 3'd2;
    localparam logic [2:0] IRQ_SET    = 3'd3;
    localparam logic [2:0] IRQ_ACTIVE = 3'd4;

    localparam int ACTIVE_VALID_BIT = 31;
    localparam int ACTIVE_ID_MSB    = 4;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync_edge
//  Description : Per-line synchroniser chain, one-cycle delayed copy and
//                rising-edge detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Programmable interrupt controller with Wishbone B3 classic
//                configuration port; drives the masked vector to the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int NUM_IRQ     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [2:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic [31:0]        irq_vec_o,
    output logic               irq_o
);
    import irq_ctrl_pkg::*;

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        zext              = '0;
        zext[NUM_IRQ-1:0] = v;
    endfunction

    bus_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] vec_q;
    logic               irq_q;
    logic [31:0]        dat_q, dat_d;

    logic [NUM_IRQ-1:0] w_s, w_rise, w_pm, w_wm, w_wbits;
    logic [31:0]        w_wm_full, w_wbits_full, w_rdata, w_active;
    logic               w_go, w_wr;
    logic               w_wr_pend, w_wr_mask, w_wr_edge, w_wr_set;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i   (wb_clk_i),
            .rst_n_i (wb_rst_n_i),
            .irq_i   (irq_i[gi]),
            .s_o     (w_s[gi]),
            .rise_o  (w_rise[gi])
        );
    end

    // A transfer is accepted only from IDLE, which makes a held strobe ack every other cycle.
    assign w_go         = (state_q == BUS_IDLE) && wb_cyc_i && wb_stb_i;
    assign w_wr         = w_go && wb_we_i;
    assign w_wr_pend    = w_wr && (wb_adr_i == IRQ_PEND);
    assign w_wr_mask    = w_wr && (wb_adr_i == IRQ_MASK);
    assign w_wr_edge    = w_wr && (wb_adr_i == IRQ_EDGE);
    assign w_wr_set     = w_wr && (wb_adr_i == IRQ_SET);
    assign w_wm_full    = byte_mask(wb_sel_i);
    assign w_wbits_full = wb_dat_i & w_wm_full;
    assign w_wm         = w_wm_full[NUM_IRQ-1:0];
    assign w_wbits      = w_wbits_full[NUM_IRQ-1:0];
    assign w_pm         = pend_q & mask_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (wb_cyc_i && wb_stb_i) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        w_active = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pm[i]) begin
                w_active[ACTIVE_VALID_BIT]  = 1'b1;
                w_active[ACTIVE_ID_MSB:0]   = 5'(i);
            end
        end
    end

    always_comb begin
        case (wb_adr_i)
            IRQ_PEND:   w_rdata = zext(pend_q);
            IRQ_MASK:   w_rdata = zext(mask_q);
            IRQ_EDGE:   w_rdata = zext(edge_q);
            IRQ_ACTIVE: w_rdata = w_active;
            default:    w_rdata = '0;
        endcase
        dat_d = (w_go && !wb_we_i) ? w_rdata : '0;
    end

    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (w_wr_mask) mask_d = (mask_q & ~w_wm) | w_wbits;
        if (w_wr_edge) edge_d = (edge_q & ~w_wm) | w_wbits;
    end

    // Edge lines: set beats clear. A line switching level->edge restarts at 0 unless it rose now.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (edge_q[i]) begin
                if (w_rise[i] || (w_wr_set && w_wbits[i])) pend_d[i] = 1'b1;
                else if (w_wr_pend && w_wbits[i])          pend_d[i] = 1'b0;
            end else if (w_wr_edge && w_wbits[i]) begin
                pend_d[i] = w_rise[i];
            end else begin
                pend_d[i] = w_s[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= BUS_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            vec_q   <= '0;
            irq_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            vec_q   <= w_pm;
            irq_q   <= |w_pm;
            dat_q   <= dat_d;
        end
    end

    assign wb_ack_o  = (state_q == BUS_ACK);
    assign wb_dat_o  = dat_q;
    assign irq_vec_o = zext(vec_q);
    assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl: reference model feeding a
//                scoreboard, directed boundary cases and a randomised phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int NUM_IRQ     = 32;
    localparam int SYNC_STAGES = 2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic [31:0] irq_i = '0;
    logic [2:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [31:0] irq_vec_o;
    logic        irq_o;

    irq_ctrl #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .irq_i      (irq_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .irq_vec_o  (irq_vec_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;
    bit          rand_irq = 0;
    logic [31:0] irq_dir  = '0;

    // Reference state
    logic [31:0] m_pend, m_mask, m_edge, m_vec;
    logic        m_irq, m_ack;
    logic [31:0] hist [0:SYNC_STAGES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Line driver: applied 2 time units after the edge so directed code can stage irq_dir first.
    initial forever begin
        @(posedge wb_clk_i);
        #2;
        if (rand_irq) irq_i = irq_i ^ ($urandom & $urandom & $urandom);
        else          irq_i = irq_dir;
    end

    // Reference model: one step per clock edge, from the register-map and line rules.
    initial begin
        m_pend = '0; m_mask = '0; m_edge = '0; m_vec = '0; m_irq = 1'b0; m_ack = 1'b0;
        for (int k = 0; k <= SYNC_STAGES; k++) hist[k] = '0;
        forever begin
            logic [31:0] s, sd, rise, pm, wm, wb, rd, np;
            logic        go, wr;
            bit          found;
            @(posedge wb_clk_i);
            if (!wb_rst_n_i) begin
                m_pend = '0; m_mask = '0; m_edge = '0; m_vec = '0;
                m_irq = 1'b0; m_ack = 1'b0;
                sb.delete();
                for (int k = 0; k <= SYNC_STAGES; k++) hist[k] = '0;
            end else begin
                s    = hist[SYNC_STAGES-1];
                sd   = hist[SYNC_STAGES];
                rise = s & ~sd;
                pm   = m_pend & m_mask;
                go   = wb_cyc_i && wb_stb_i && !m_ack;
                wr   = go && wb_we_i;
                wm   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
                wb   = wb_dat_i & wm;
                rd   = '0;
                case (wb_adr_i)
                    3'd0: rd = m_pend;
                    3'd1: rd = m_mask;
                    3'd2: rd = m_edge;
                    3'd4: begin
                        found = 0;
                        for (int i = 0; i < NUM_IRQ; i++)
                            if (!found && pm[i]) begin
                                found = 1;
                                rd = 32'h8000_0000 | i;
                            end
                    end
                    default: rd = '0;
                endcase
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (m_edge[i]) begin
                        if (rise[i] || (wr && wb_adr_i == 3'd3 && wb[i]))  np[i] = 1'b1;
                        else if (wr && wb_adr_i == 3'd0 && wb[i])          np[i] = 1'b0;
                        else                                               np[i] = m_pend[i];
                    end else if (wr && wb_adr_i == 3'd2 && wb[i]) begin
                        np[i] = rise[i];
                    end else begin
                        np[i] = s[i];
                    end
                end
                if (wr && wb_adr_i == 3'd1) m_mask = (m_mask & ~wm) | wb;
                if (wr && wb_adr_i == 3'd2) m_edge = (m_edge & ~wm) | wb;
                m_pend = np;
                m_vec  = pm;
                m_irq  = |pm;
                m_ack  = go;
                if (go) sb.push_back('{rd: !wb_we_i, exp: rd});
                for (int k = SYNC_STAGES; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = irq_i;
            end
        end
    end

    // Monitor: compares outputs every cycle and retires scoreboard entries on ack.
    initial forever begin
        @(negedge wb_clk_i);
        if (mon_en) begin
            check("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
            check("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
            check("irq_vec_o", irq_vec_o, m_vec);
            if (wb_ack_o) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got ack=1 expected no transfer outstanding");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.rd) check("rdata", wb_dat_o, e.exp);
                end
            end
        end
    end

    task automatic bus_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        got  = 0;
        rdat = '0;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge wb_clk_i);
            #1;
            if (wb_ack_o) begin
                got  = 1;
                rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("bus_ack_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
        logic [31:0] unused;
        bus_xfer(adr, 1'b1, dat, 4'hF, unused);
    endtask

    task automatic rd_check(input string name, input logic [2:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(adr, 1'b0, '0, 4'hF, d);
        check(name, d, exp);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [31:0] d;

        // Reset with all lines high
        irq_dir = '1;
        @(posedge wb_clk_i);
        #1;
        mon_en = 1;
        cycles(4);
        check("reset_irq_o", {31'b0, irq_o}, 32'd0);
        check("reset_vec", irq_vec_o, 32'd0);
        irq_dir = '0;
        cycles(1);
        wb_rst_n_i = 1'b1;
        rd_check("reset_pend", 3'd0, 32'd0);
        rd_check("reset_mask", 3'd1, 32'd0);
        rd_check("reset_edge", 3'd2, 32'd0);

        // Level path on line 0
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h0);
        irq_dir[0] = 1'b1;
        cycles(5);
        check("level_irq_high", {31'b0, irq_o}, 32'd1);
        rd_check("level_active", 3'd4, 32'h8000_0000);
        irq_dir[0] = 1'b0;
        cycles(5);
        check("level_irq_low", {31'b0, irq_o}, 32'd0);

        // Edge latch on line 8
        wr(3'd2, 32'h100);
        wr(3'd1, 32'h100);
        irq_dir[8] = 1'b1;
        cycles(1);
        irq_dir[8] = 1'b0;
        cycles(5);
        rd_check("edge_pend", 3'd0, 32'h100);
        check("edge_irq_held", {31'b0, irq_o}, 32'd1);
        wr(3'd0, 32'h100);
        cycles(1);
        check("edge_w1c_irq", {31'b0, irq_o}, 32'd0);

        // Rise of line 3 lands on the W1C commit edge
        wr(3'd2, 32'h108);
        irq_dir[3] = 1'b1;
        cycles(2);
        wr(3'd0, 32'h8);
        rd_check("set_wins_pend", 3'd0, 32'h8);

        // Priority and mask
        wr(3'd2, 32'h2C);
        wr(3'd3, 32'h24);
        wr(3'd0, 32'h08);
        irq_dir[3] = 1'b0;
        wr(3'd1, 32'h24);
        rd_check("prio_id2", 3'd4, 32'h8000_0002);
        wr(3'd1, 32'h20);
        rd_check("prio_id5", 3'd4, 32'h8000_0005);
        rd_check("prio_pend", 3'd0, 32'h24);

        // Byte-lane write, unmapped read
        wr(3'd1, 32'h0);
        bus_xfer(3'd1, 1'b1, 32'hFFFF_FFFF, 4'b0010, d);
        rd_check("sel_mask", 3'd1, 32'h0000_FF00);
        rd_check("addr7", 3'd7, 32'h0);

        // Held strobe
        acks = 0;
        wb_adr_i = 3'd1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("held_stb_acks", acks, 32'd3);

        // Reset in the middle of a cycle
        wb_adr_i = 3'd0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_rst_n_i = 1'b0;
        cycles(1);
        check("rst_mid_ack", {31'b0, wb_ack_o}, 32'd0);
        cycles(1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_rst_n_i = 1'b1;
        cycles(1);
        check("rst_mid_ack_after", {31'b0, wb_ack_o}, 32'd0);

        // Randomised traffic against the model
        rand_irq = 1;
        for (int t = 0; t < 300; t++) begin
            logic [3:0] sel;
            cycles($urandom_range(0, 3));
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            bus_xfer(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, sel, d);
        end
        rand_irq = 0;
        cycles(6);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
